// File: rtl/ifu_fetch.sv
// Instruction fetch unit for the multicycle RV32 core: one AXI-lite read per
// instruction, holds the word for decode, then waits for the next PC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        pc_update_valid,
    input  logic [31:0] pc_next,
    output logic        fetch_err
);

    localparam logic [2:0] ST_REQ     = 3'd0;
    localparam logic [2:0] ST_RESP    = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_WAIT_PC = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic        err_q, err_d;
    logic        take_pc;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        err_d   = err_q;
        take_pc = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (arready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rvalid) begin
                    if (rresp == 2'b00) begin
                        ins_d   = rdata;
                        state_d = ST_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HOLD: begin
                if (ins_ready) begin
                    if (pc_update_valid) begin
                        take_pc = 1'b1;
                    end else begin
                        state_d = ST_WAIT_PC;
                    end
                end
            end
            ST_WAIT_PC: begin
                take_pc = pc_update_valid;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                err_d   = 1'b1;
                state_d = ST_HALT;
            end
        endcase

        // A misaligned next PC cannot be fetched, so the core halts with the error flag.
        if (take_pc) begin
            pc_d = pc_next;
            if (pc_next[1:0] == 2'b00) begin
                state_d = ST_REQ;
            end else begin
                err_d   = 1'b1;
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            ins_q   <= NOP;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            err_q   <= err_d;
        end
    end

    // State is already REQ while reset is held, so arvalid is gated by rst_n itself.
    assign arvalid   = rst_n && (state_q == ST_REQ);
    assign araddr    = pc_q;
    assign rready    = (state_q == ST_RESP);
    assign ins_valid = (state_q == ST_HOLD);
    assign ins       = ins_q;
    assign pc        = pc_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written
// corner-case sequences and randomized traffic against a transaction-level model.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        pc_update_valid;
    logic [31:0] pc_next;
    logic        fetch_err;

    int assertCount = 0;
    int failCount   = 0;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .ins(ins), .pc(pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .pc_update_valid(pc_update_valid),
        .pc_next(pc_next), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Transaction-level view: which handshake is outstanding, not an FSM encoding.
    bit          mAddrPending, mDataPending, mInsHeld, mNeedPc, mHalted;
    logic [31:0] mPc, mIns;

    function automatic void modelReset();
        mAddrPending = 1'b1;
        mDataPending = 1'b0;
        mInsHeld     = 1'b0;
        mNeedPc      = 1'b0;
        mHalted      = 1'b0;
        mPc          = RST_PC;
        mIns         = NOP;
    endfunction

    function automatic void modelTakePc(input logic [31:0] nextPc);
        mPc = nextPc;
        if (nextPc % 4 == 0) mAddrPending = 1'b1;
        else                 mHalted      = 1'b1;
    endfunction

    function automatic void modelStep();
        if (mHalted) return;
        if (mAddrPending) begin
            if (arready) begin
                mAddrPending = 1'b0;
                mDataPending = 1'b1;
            end
        end else if (mDataPending) begin
            if (rvalid) begin
                mDataPending = 1'b0;
                if (rresp == 2'b00) begin
                    mIns     = rdata;
                    mInsHeld = 1'b1;
                end else begin
                    mHalted = 1'b1;
                end
            end
        end else if (mInsHeld) begin
            if (ins_ready) begin
                mInsHeld = 1'b0;
                if (pc_update_valid) modelTakePc(pc_next);
                else                 mNeedPc = 1'b1;
            end
        end else if (mNeedPc) begin
            if (pc_update_valid) begin
                mNeedPc = 1'b0;
                modelTakePc(pc_next);
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_arvalid"},   32'(arvalid),   32'(mAddrPending));
        checkOutput({tag, "_araddr"},    araddr,         mPc);
        checkOutput({tag, "_rready"},    32'(rready),    32'(mDataPending));
        checkOutput({tag, "_ins_valid"}, 32'(ins_valid), 32'(mInsHeld));
        checkOutput({tag, "_ins"},       ins,            mIns);
        checkOutput({tag, "_pc"},        pc,             mPc);
        checkOutput({tag, "_fetch_err"}, 32'(fetch_err), 32'(mHalted));
    endtask

    task automatic applyStimulus(input logic ar, input logic rv, input logic [1:0] rr,
                                 input logic [31:0] rd, input logic ir, input logic pu,
                                 input logic [31:0] pn);
        arready         = ar;
        rvalid          = rv;
        rresp           = rr;
        rdata           = rd;
        ins_ready       = ir;
        pc_update_valid = pu;
        pc_next         = pn;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        ins_ready = 1'b0; pc_update_valid = 1'b0; pc_next = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_arvalid_low", 32'(arvalid), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_first_arvalid", 32'(arvalid), 32'd1);
        checkOutput("rst_first_araddr", araddr, RST_PC);
        checkOutput("rst_fetch_err", 32'(fetch_err), 32'd0);
        checkOutput("rst_ins_nop", ins, NOP);
    endtask

    typedef struct {
        logic        ar, rv;
        logic [1:0]  rr;
        logic [31:0] rd;
        logic        ir, pu;
        logic [31:0] pn;
        logic        eArvalid, eRready, eInsValid, eErr;
        logic [31:0] ePc, eIns;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int insValidSeen;

        // ar rv rr rd ir pu pn | arvalid rready insvalid err pc ins
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, NOP};
        vecs[1]  = '{1'b0, 1'b1, 2'b00, 32'h0010_0093, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0010_0093};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h8000_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0010_0093};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0010_0093};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0010_0093};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0010_0093};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0010_0093};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0010_0093};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0010_0093};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0010_0093};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF};
        vecs[13] = '{1'b0, 1'b1, 2'b10, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF};
        vecs[14] = '{1'b1, 1'b1, 2'b00, 32'h2222_2222, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF};

        applyReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ar, vecs[i].rv, vecs[i].rr, vecs[i].rd,
                          vecs[i].ir, vecs[i].pu, vecs[i].pn);
            checkOutput($sformatf("vec%0d_arvalid", i),   32'(arvalid),   32'(vecs[i].eArvalid));
            checkOutput($sformatf("vec%0d_araddr", i),    araddr,         vecs[i].ePc);
            checkOutput($sformatf("vec%0d_rready", i),    32'(rready),    32'(vecs[i].eRready));
            checkOutput($sformatf("vec%0d_ins_valid", i), 32'(ins_valid), 32'(vecs[i].eInsValid));
            checkOutput($sformatf("vec%0d_fetch_err", i), 32'(fetch_err), 32'(vecs[i].eErr));
            checkOutput($sformatf("vec%0d_pc", i),        pc,             vecs[i].ePc);
            checkOutput($sformatf("vec%0d_ins", i),       ins,            vecs[i].eIns);
        end

        // Halted after an error response: a reset pulse clears the flag and refetches.
        applyReset();

        // Slow memory: address held across a delayed arready, single capture.
        insValidSeen = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
            checkModel("slow_ar");
            checkOutput("slow_araddr_stable", araddr, RST_PC);
        end
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkModel("slow_ar_accept");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
            checkModel("slow_r");
            insValidSeen += int'(ins_valid);
        end
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h00A0_0113, 1'b0, 1'b0, 32'h0);
        checkModel("slow_r_data");
        insValidSeen += int'(ins_valid);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0);
        checkModel("slow_consume");
        insValidSeen += int'(ins_valid);
        checkOutput("slow_ins_valid_once", 32'(insValidSeen), 32'd1);
        checkOutput("slow_ins_kept", ins, 32'h00A0_0113);

        // Misaligned next PC while waiting for it.
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h8000_0006);
        checkOutput("misalign_err", 32'(fetch_err), 32'd1);
        checkOutput("misalign_pc", pc, 32'h8000_0006);
        checkModel("misalign");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 32'h0, 1'b1, 1'b1, 32'h8000_0020);
            checkOutput("misalign_no_arvalid", 32'(arvalid), 32'd0);
        end

        // Asynchronous reset while waiting for read data.
        applyReset();
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("async_in_resp", 32'(rready), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rready_cleared", 32'(rready), 32'd0);
        checkOutput("async_arvalid_cleared", 32'(arvalid), 32'd0);
        checkOutput("async_pc_reset", pc, RST_PC);
        rvalid = 1'b1;
        rdata  = 32'h7777_7777;
        @(posedge clk);
        #1;
        checkOutput("async_late_rvalid_ignored", ins, NOP);
        rst_n = 1'b1;
        modelReset();
        #1;
        checkOutput("async_refetch_arvalid", 32'(arvalid), 32'd1);
        checkOutput("async_refetch_araddr", araddr, RST_PC);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
        checkModel("async_after");

        // Randomized traffic against the model.
        applyReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0]  rr;
            logic [31:0] pn;
            rr = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pn = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) pn[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(1'($urandom), 1'($urandom), rr, $urandom, 1'($urandom),
                          ($urandom_range(0, 2) == 0), pn);
            checkModel("rand");
            if (mHalted && $urandom_range(0, 3) == 0) applyReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
